// File: rtl/csa_accum_pkg.sv
// Shared types and constants for the carry-save packet accumulator.
package csa_accum_pkg;

    localparam int DATA_W          = 32;
    localparam int HI_W            = 8;
    localparam int CNT_W           = 9;
    localparam int MAX_OPS_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

endpackage : csa_accum_pkg

// File: rtl/csa_accum_seq_adders.sv
// Arithmetic building blocks used by csa_accum_seq:
//   AdderCS32bit - 3:2 carry-save compressor (carry returned unshifted)
//   AdderLC32bit - 32-bit adder, 4-bit lookahead groups with a group carry chain

module AdderCS32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic [31:0] sum,
    output logic [31:0] carry
);

    // Bitwise full-adder: carry[i] has weight 2^(i+1).
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule : AdderCS32bit

module AdderLC32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g_s;
    logic [31:0] p_s;
    logic [31:0] c_s;
    logic [7:0]  gg_s;
    logic [7:0]  gp_s;
    logic [8:0]  gc_s;

    assign g_s     = a & b;
    assign p_s     = a ^ b;
    assign gc_s[0] = cin;

    // Each 4-bit group resolves its internal carries directly from its group carry-in.
    for (genvar k = 0; k < 8; k++) begin : g_grp
        localparam int B = 4 * k;

        assign gg_s[k] = g_s[B+3]
                       | (p_s[B+3] & g_s[B+2])
                       | (p_s[B+3] & p_s[B+2] & g_s[B+1])
                       | (p_s[B+3] & p_s[B+2] & p_s[B+1] & g_s[B]);
        assign gp_s[k] = &p_s[B+3:B];
        assign gc_s[k+1] = gg_s[k] | (gp_s[k] & gc_s[k]);

        assign c_s[B]   = gc_s[k];
        assign c_s[B+1] = g_s[B] | (p_s[B] & gc_s[k]);
        assign c_s[B+2] = g_s[B+1] | (p_s[B+1] & g_s[B]) | (p_s[B+1] & p_s[B] & gc_s[k]);
        assign c_s[B+3] = g_s[B+2] | (p_s[B+2] & g_s[B+1]) | (p_s[B+2] & p_s[B+1] & g_s[B])
                        | (p_s[B+2] & p_s[B+1] & p_s[B] & gc_s[k]);
    end

    assign sum  = p_s ^ c_s;
    assign cout = gc_s[8];

endmodule : AdderLC32bit

// File: rtl/csa_accum_seq.sv
// Packet accumulator: folds operands into redundant carry-save state (S, C)
// plus an 8-bit overflow byte, then resolves to a 40-bit sum in one cycle.
// The carry register C is kept unshifted; it is shifted left by one when it
// is used, and its top bit (weight 2^32) is folded into the hi byte.

module csa_accum_seq
    import csa_accum_pkg::*;
#(
    parameter int MAX_OPS = MAX_OPS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [HI_W-1:0]   out_hi,
    output logic [CNT_W-1:0]  out_cnt
);

    localparam logic [CNT_W-1:0] MAX_OPS_CNT = CNT_W'(MAX_OPS);

    state_t              state_r,   state_s;
    logic [DATA_W-1:0]   s_r,       s_s;
    logic [DATA_W-1:0]   c_r,       c_s;
    logic [HI_W-1:0]     hi_r,      hi_s;
    logic [CNT_W-1:0]    cnt_r,     cnt_s;
    logic [DATA_W-1:0]   out_sum_r, out_sum_s;
    logic [HI_W-1:0]     out_hi_r,  out_hi_s;
    logic [CNT_W-1:0]    out_cnt_r, out_cnt_s;
    logic                in_ready_r, in_ready_s;
    logic                out_valid_r, out_valid_s;

    logic                in_fire_s;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [DATA_W-1:0]   c_shl_s;
    logic [DATA_W-1:0]   csa_sum_s;
    logic [DATA_W-1:0]   csa_carry_s;
    logic [DATA_W-1:0]   add_sum_s;
    logic                add_cout_s;

    assign c_shl_s   = {c_r[DATA_W-2:0], 1'b0};
    assign in_fire_s = in_valid & in_ready_r;
    assign cnt_inc_s = cnt_r + 9'd1;

    AdderCS32bit u_csa (
        .a     (s_r),
        .b     (c_shl_s),
        .c     (in_data),
        .sum   (csa_sum_s),
        .carry (csa_carry_s)
    );

    AdderLC32bit u_resolve (
        .a    (s_r),
        .b    (c_shl_s),
        .cin  (1'b0),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Next-state, redundant-state update and output staging.
    always_comb begin
        state_s     = state_r;
        s_s         = s_r;
        c_s         = c_r;
        hi_s        = hi_r;
        cnt_s       = cnt_r;
        out_sum_s   = out_sum_r;
        out_hi_s    = out_hi_r;
        out_cnt_s   = out_cnt_r;

        case (state_r)
            IDLE: begin
                if (in_fire_s) begin
                    s_s   = in_data;
                    c_s   = 32'd0;
                    hi_s  = 8'd0;
                    cnt_s = 9'd1;
                    if (in_last || (MAX_OPS_CNT == 9'd1)) begin
                        state_s = RESOLVE;
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (in_fire_s) begin
                    s_s   = csa_sum_s;
                    c_s   = csa_carry_s;
                    hi_s  = hi_r + {7'd0, c_r[DATA_W-1]};
                    cnt_s = cnt_inc_s;
                    if (in_last || (cnt_inc_s == MAX_OPS_CNT)) begin
                        state_s = RESOLVE;
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            RESOLVE: begin
                out_sum_s = add_sum_s;
                out_hi_s  = hi_r + {7'd0, c_r[DATA_W-1]} + {7'd0, add_cout_s};
                out_cnt_s = cnt_r;
                state_s   = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = OUTPUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        in_ready_s  = (state_s == IDLE) || (state_s == ACCUM);
        out_valid_s = (state_s == OUTPUT);
    end

    // State and datapath registers; reset discards any packet in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            s_r         <= 32'd0;
            c_r         <= 32'd0;
            hi_r        <= 8'd0;
            cnt_r       <= 9'd0;
            out_sum_r   <= 32'd0;
            out_hi_r    <= 8'd0;
            out_cnt_r   <= 9'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            s_r         <= s_s;
            c_r         <= c_s;
            hi_r        <= hi_s;
            cnt_r       <= cnt_s;
            out_sum_r   <= out_sum_s;
            out_hi_r    <= out_hi_s;
            out_cnt_r   <= out_cnt_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_hi    = out_hi_r;
    assign out_cnt   = out_cnt_r;

endmodule : csa_accum_seq
